// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM state encoding,
// requester identifiers and default bus widths.
package vram_arb_pkg;

    localparam int VRAM_AW       = 13;
    localparam int VRAM_DW       = 8;
    localparam int VRAM_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [1:0] REQ_PPU = 2'd0;
    localparam logic [1:0] REQ_DMA = 2'd1;
    localparam logic [1:0] REQ_CPU = 2'd2;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side and memory-side signals of the VRAM arbiter.
// The arbiter uses the slave modport; the core/memory side uses master.
interface vram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          ppu_req,   dma_req,   cpu_req;
    logic          ppu_we,    dma_we,    cpu_we;
    logic [AW-1:0] ppu_addr,  dma_addr,  cpu_addr;
    logic [DW-1:0] ppu_wdata, dma_wdata, cpu_wdata;
    logic          ppu_ack,   dma_ack,   cpu_ack;
    logic [DW-1:0] ppu_rdata, dma_rdata, cpu_rdata;
    logic [1:0]    ppu_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr_cs;
    logic          mem_rd_cs;
    logic [DW-1:0] mem_rdata;
    logic          cpu_promoted;

    modport slave (
        input  ppu_req, dma_req, cpu_req, ppu_we, dma_we, cpu_we,
        input  ppu_addr, dma_addr, cpu_addr, ppu_wdata, dma_wdata, cpu_wdata,
        input  ppu_mode, mem_rdata,
        output ppu_ack, dma_ack, cpu_ack, ppu_rdata, dma_rdata, cpu_rdata,
        output mem_addr, mem_wdata, mem_wr_cs, mem_rd_cs, cpu_promoted
    );

    modport master (
        output ppu_req, dma_req, cpu_req, ppu_we, dma_we, cpu_we,
        output ppu_addr, dma_addr, cpu_addr, ppu_wdata, dma_wdata, cpu_wdata,
        output ppu_mode, mem_rdata,
        input  ppu_ack, dma_ack, cpu_ack, ppu_rdata, dma_rdata, cpu_rdata,
        input  mem_addr, mem_wdata, mem_wr_cs, mem_rd_cs, cpu_promoted
    );
endinterface

// File: rtl/vram_arb_prio.sv
// Combinational priority picker: PPU > DMA > CPU, unless the CPU has been
// promoted by the starvation guard, in which case a pending CPU wins.
module vram_arb_prio
    import vram_arb_pkg::*;
(
    input  logic       ppu_req_i,
    input  logic       dma_req_i,
    input  logic       cpu_req_i,
    input  logic       promote_i,
    output logic       valid_o,
    output logic [1:0] winner_o
);

    // Pick the highest-priority pending requester.
    always_comb begin
        valid_o  = ppu_req_i | dma_req_i | cpu_req_i;
        winner_o = REQ_PPU;
        if (promote_i && cpu_req_i) begin
            winner_o = REQ_CPU;
        end else if (ppu_req_i) begin
            winner_o = REQ_PPU;
        end else if (dma_req_i) begin
            winner_o = REQ_DMA;
        end else if (cpu_req_i) begin
            winner_o = REQ_CPU;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Three-way arbiter for the single-port VRAM (PPU, OAM DMA, CPU).
// Each access takes IDLE -> ACCESS -> ACK; the strobe is asserted during
// ACCESS and the winner's ack pulses during ACK with its read data held.
// Optional build macro VRAM_LOCKOUT_EN: CPU accesses granted while the PPU is
// in mode 3 never reach memory (reads return all-ones, writes are dropped).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int DW       = VRAM_DW,
    parameter int MAX_WAIT = VRAM_MAX_WAIT
) (
    input  logic           clock,
    input  logic           reset_n,
    vram_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [1:0]    win_q, win_d;
    logic          we_q, we_d;
    logic          lock_q, lock_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_cs_q, wr_cs_d;
    logic          rd_cs_q, rd_cs_d;
    logic [2:0]    ack_q, ack_d;
    logic [DW-1:0] rdata_q [3];
    logic [DW-1:0] rdata_d [3];
    logic [3:0]    starv_q, starv_d;

    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_lock;

    vram_arb_prio u_prio (
        .ppu_req_i (bus.ppu_req),
        .dma_req_i (bus.dma_req),
        .cpu_req_i (bus.cpu_req),
        .promote_i (starv_q == MAX_CNT),
        .valid_o   (grant_valid),
        .winner_o  (grant_id)
    );

    // Route the winner's access fields; losers' data is never looked at.
    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (grant_id == REQ_PPU) begin
            sel_we    = bus.ppu_we;
            sel_addr  = bus.ppu_addr;
            sel_wdata = bus.ppu_wdata;
        end else if (grant_id == REQ_DMA) begin
            sel_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

`ifdef VRAM_LOCKOUT_EN
    assign sel_lock = (grant_id == REQ_CPU) && (bus.ppu_mode == 2'b11);
`else
    logic unused_mode;
    assign unused_mode = ^bus.ppu_mode;
    assign sel_lock    = 1'b0;
`endif

    // Next-state and datapath decisions for the IDLE/ACCESS/ACK sequence.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        lock_d  = lock_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_cs_d = 1'b0;
        rd_cs_d = 1'b0;
        ack_d   = 3'b000;
        rdata_d = rdata_q;
        starv_d = starv_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                    win_d   = grant_id;
                    we_d    = sel_we;
                    lock_d  = sel_lock;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wr_cs_d = sel_we & ~sel_lock;
                    rd_cs_d = ~sel_we & ~sel_lock;
                    if (grant_id == REQ_CPU) begin
                        starv_d = 4'd0;
                    end else if (bus.cpu_req && (starv_q != MAX_CNT)) begin
                        starv_d = starv_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                state_d       = ACK;
                ack_d[win_q]  = 1'b1;
                if (!we_q) begin
                    rdata_d[win_q] = lock_q ? {DW{1'b1}} : bus.mem_rdata;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= REQ_PPU;
            we_q    <= 1'b0;
            lock_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_cs_q <= 1'b0;
            rd_cs_q <= 1'b0;
            ack_q   <= 3'b000;
            rdata_q <= '{default: '0};
            starv_q <= 4'd0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            lock_q  <= lock_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_cs_q <= wr_cs_d;
            rd_cs_q <= rd_cs_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            starv_q <= starv_d;
        end
    end

    assign bus.ppu_ack      = ack_q[REQ_PPU];
    assign bus.dma_ack      = ack_q[REQ_DMA];
    assign bus.cpu_ack      = ack_q[REQ_CPU];
    assign bus.ppu_rdata    = rdata_q[REQ_PPU];
    assign bus.dma_rdata    = rdata_q[REQ_DMA];
    assign bus.cpu_rdata    = rdata_q[REQ_CPU];
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wr_cs    = wr_cs_q;
    assign bus.mem_rd_cs    = rd_cs_q;
    assign bus.cpu_promoted = (starv_q == MAX_CNT);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter. Stimulus is issued as batches of
// per-requester operation lists; a transaction-level model predicts grant
// order, ack cycles, read data and the promotion flag, and a monitor
// compares every strobe and ack against the predicted queue.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int MAX_WAIT = 4;
`ifdef VRAM_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
        logic          promoted;
        logic          locked;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // VRAM: synchronous write, asynchronous read, preloaded on the first edge.
    logic [DW-1:0] vram [1 << AW];
    bit mem_ready = 1'b0;
    assign bus.mem_rdata = vram[bus.mem_addr];
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) vram[i] <= 8'(i * 7 + 3);
            mem_ready <= 1'b1;
        end else if (bus.mem_wr_cs) begin
            vram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Reference state
    logic [DW-1:0] ref_mem [1 << AW];
    int            m_starv = 0;
    logic [DW-1:0] m_rdata [3];
    exp_t          exp_q [$];
    op_t           plan [3][16];
    int            plan_n [3];
    logic [1:0]    cur_mode = 2'b00;

    task automatic check(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    function automatic logic get_ack(input int r);
        case (r)
            0: return bus.ppu_ack;
            1: return bus.dma_ack;
            default: return bus.cpu_ack;
        endcase
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int r);
        case (r)
            0: return bus.ppu_rdata;
            1: return bus.dma_rdata;
            default: return bus.cpu_rdata;
        endcase
    endfunction

    task automatic set_bus(input int r, input op_t op, input logic req);
        case (r)
            0: begin bus.ppu_req = req; bus.ppu_we = op.we; bus.ppu_addr = op.addr; bus.ppu_wdata = op.wdata; end
            1: begin bus.dma_req = req; bus.dma_we = op.we; bus.dma_addr = op.addr; bus.dma_wdata = op.wdata; end
            default: begin bus.cpu_req = req; bus.cpu_we = op.we; bus.cpu_addr = op.addr; bus.cpu_wdata = op.wdata; end
        endcase
    endtask

    task automatic clear_plan();
        for (int r = 0; r < 3; r++) plan_n[r] = 0;
    endtask

    task automatic add_op(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        plan[r][plan_n[r]].we    = we;
        plan[r][plan_n[r]].addr  = a;
        plan[r][plan_n[r]].wdata = d;
        plan_n[r]++;
    endtask

    // Transaction-level model: every requester with ops left is pending at
    // each arbitration; one grant every 3 cycles starting 2 cycles after start.
    task automatic run_model(input int start);
        int idx [3];
        int k;
        k = 0;
        for (int r = 0; r < 3; r++) idx[r] = 0;
        while (idx[0] < plan_n[0] || idx[1] < plan_n[1] || idx[2] < plan_n[2]) begin
            bit   pend [3];
            int   w;
            op_t  op;
            exp_t e;
            for (int r = 0; r < 3; r++) pend[r] = (idx[r] < plan_n[r]);
            if (pend[2] && m_starv == MAX_WAIT) w = 2;
            else if (pend[0]) w = 0;
            else if (pend[1]) w = 1;
            else w = 2;
            if (w == 2) m_starv = 0;
            else if (pend[2] && m_starv < MAX_WAIT) m_starv++;
            op = plan[w][idx[w]];
            idx[w]++;
            e.id       = w;
            e.we       = op.we;
            e.addr     = op.addr;
            e.wdata    = op.wdata;
            e.cyc      = start + 2 + 3 * k;
            e.promoted = (m_starv == MAX_WAIT);
            e.locked   = LOCKOUT && (w == 2) && (cur_mode == 2'b11);
            e.rdata    = '0;
            if (op.we) begin
                if (!e.locked) ref_mem[op.addr] = op.wdata;
            end else begin
                e.rdata = e.locked ? 8'hFF : ref_mem[op.addr];
            end
            exp_q.push_back(e);
            k++;
        end
    endtask

    task automatic drive(input int r);
        op_t idle_op;
        idle_op.we = 1'b0; idle_op.addr = '0; idle_op.wdata = '0;
        for (int i = 0; i < plan_n[r]; i++) begin
            bit got;
            got = 1'b0;
            set_bus(r, plan[r][i], 1'b1);
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge clock);
                got = get_ack(r);
            end
            if (!got) begin
                check(1'b0, $sformatf("ack_timeout req=%0d got=0 want=1", r));
                set_bus(r, idle_op, 1'b0);
                return;
            end
        end
        set_bus(r, idle_op, 1'b0);
    endtask

    task automatic run_batch(input logic [1:0] mode);
        int start;
        @(negedge clock);
        start = cyc;
        cur_mode = mode;
        bus.ppu_mode = mode;
        run_model(start);
        fork
            drive(0);
            drive(1);
            drive(2);
        join
        repeat (2) @(negedge clock);
    endtask

    // Monitor: compare strobes and acks against the predicted queue.
    bit seen_strobe = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                for (int r = 0; r < 3; r++) m_rdata[r] = '0;
                seen_strobe = 1'b0;
                check({bus.ppu_ack, bus.dma_ack, bus.cpu_ack, bus.mem_wr_cs, bus.mem_rd_cs, bus.cpu_promoted} == 6'b0
                      && bus.ppu_rdata == 0 && bus.dma_rdata == 0 && bus.cpu_rdata == 0
                      && bus.mem_addr == 0 && bus.mem_wdata == 0,
                      $sformatf("reset_outs got ack=%b%b%b wr=%b rd=%b prom=%b addr=%h wd=%h rd=%h/%h/%h want all 0",
                                bus.ppu_ack, bus.dma_ack, bus.cpu_ack, bus.mem_wr_cs, bus.mem_rd_cs,
                                bus.cpu_promoted, bus.mem_addr, bus.mem_wdata,
                                bus.ppu_rdata, bus.dma_rdata, bus.cpu_rdata));
            end else begin
                if (bus.mem_wr_cs || bus.mem_rd_cs) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, $sformatf("unexpected_strobe cyc=%0d wr=%b rd=%b want none",
                                              cyc, bus.mem_wr_cs, bus.mem_rd_cs));
                    end else begin
                        exp_t e;
                        e = exp_q[0];
                        check(cyc == e.cyc - 1 && bus.mem_wr_cs == e.we && bus.mem_rd_cs == !e.we
                              && !e.locked && bus.mem_addr == e.addr && (!e.we || bus.mem_wdata == e.wdata),
                              $sformatf("strobe got cyc=%0d wr=%b rd=%b addr=%h wd=%h want cyc=%0d we=%b locked=%b addr=%h wd=%h",
                                        cyc, bus.mem_wr_cs, bus.mem_rd_cs, bus.mem_addr, bus.mem_wdata,
                                        e.cyc - 1, e.we, e.locked, e.addr, e.wdata));
                    end
                    seen_strobe = 1'b1;
                end
                if (bus.ppu_ack || bus.dma_ack || bus.cpu_ack) begin
                    int r;
                    r = bus.ppu_ack ? 0 : (bus.dma_ack ? 1 : 2);
                    check(int'(bus.ppu_ack) + int'(bus.dma_ack) + int'(bus.cpu_ack) == 1,
                          $sformatf("one_ack got=%b%b%b want one-hot", bus.ppu_ack, bus.dma_ack, bus.cpu_ack));
                    if (exp_q.size() == 0) begin
                        check(1'b0, $sformatf("unexpected_ack req=%0d cyc=%0d want none", r, cyc));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check(r == e.id && cyc == e.cyc,
                              $sformatf("ack_order got req=%0d cyc=%0d want req=%0d cyc=%0d", r, cyc, e.id, e.cyc));
                        check(bus.cpu_promoted == e.promoted,
                              $sformatf("promoted got=%b want=%b", bus.cpu_promoted, e.promoted));
                        check(seen_strobe == !e.locked,
                              $sformatf("strobe_seen got=%b want=%b", seen_strobe, !e.locked));
                        if (!e.we) begin
                            check(get_rdata(r) == e.rdata,
                                  $sformatf("rdata req=%0d addr=%h got=%h want=%h", r, e.addr, get_rdata(r), e.rdata));
                            m_rdata[r] = e.rdata;
                        end
                        for (int q = 0; q < 3; q++) begin
                            check(get_rdata(q) == m_rdata[q],
                                  $sformatf("rdata_held req=%0d got=%h want=%h", q, get_rdata(q), m_rdata[q]));
                        end
                    end
                    seen_strobe = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t z;
        z.we = 1'b0; z.addr = '0; z.wdata = '0;
        for (int r = 0; r < 3; r++) begin
            set_bus(r, z, 1'b0);
            m_rdata[r] = '0;
        end
        bus.ppu_mode = 2'b00;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'(i * 7 + 3);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // CPU write then read-back
        clear_plan(); add_op(2, 1'b1, 13'h0010, 8'hA5); run_batch(2'b00);
        clear_plan(); add_op(2, 1'b0, 13'h0010, 8'h00); run_batch(2'b00);

        // All three at once: PPU, DMA, CPU
        clear_plan();
        add_op(0, 1'b0, 13'h0010, 8'h00);
        add_op(1, 1'b1, 13'h0020, 8'h11);
        add_op(2, 1'b0, 13'h0020, 8'h00);
        run_batch(2'b00);

        // Starvation: PPU/DMA keep re-requesting, CPU waits
        clear_plan();
        for (int i = 0; i < 4; i++) begin
            add_op(0, 1'b0, 13'(i), 8'h00);
            add_op(1, 1'b0, 13'(i + 8), 8'h00);
        end
        add_op(2, 1'b0, 13'h0010, 8'h00);
        run_batch(2'b00);

        // Reset during a DMA write to the top address
        clear_plan(); add_op(1, 1'b1, 13'h1FFF, 8'h5A); run_batch(2'b00);
        @(negedge clock);
        bus.dma_we = 1'b1; bus.dma_addr = 13'h1FFF; bus.dma_wdata = 8'hC3; bus.dma_req = 1'b1;
        @(posedge clock);
        #1;
        check(bus.mem_wr_cs == 1'b1, $sformatf("rst_pre_strobe got=%b want=1", bus.mem_wr_cs));
        reset_n = 1'b0;
        #1;
        check(bus.mem_wr_cs == 1'b0, $sformatf("rst_async_clear got=%b want=0", bus.mem_wr_cs));
        repeat (3) @(negedge clock);
        bus.dma_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        m_starv = 0;
        clear_plan();
        add_op(1, 1'b0, 13'h1FFF, 8'h00);
        add_op(2, 1'b0, 13'h0010, 8'h00);
        run_batch(2'b00);

        // PPU mode 3 lockout sequence (plain pass-through without the macro)
        clear_plan(); add_op(2, 1'b1, 13'h0040, 8'h3C); run_batch(2'b00);
        clear_plan(); add_op(2, 1'b0, 13'h0040, 8'h00); run_batch(2'b11);
        clear_plan(); add_op(2, 1'b1, 13'h0040, 8'h77); run_batch(2'b11);
        clear_plan(); add_op(2, 1'b0, 13'h0040, 8'h00); run_batch(2'b00);
        clear_plan(); add_op(0, 1'b0, 13'h0040, 8'h00); add_op(1, 1'b0, 13'h0040, 8'h00); run_batch(2'b11);

        // Address wrap boundary, DMA back-to-back
        clear_plan(); add_op(1, 1'b0, 13'h1FFF, 8'h00); add_op(1, 1'b0, 13'h0000, 8'h00); run_batch(2'b00);

        // Random batches
        for (int b = 0; b < 40; b++) begin
            clear_plan();
            for (int r = 0; r < 3; r++) begin
                int n;
                n = $urandom_range(0, (r == 2) ? 2 : 4);
                for (int i = 0; i < n; i++) begin
                    logic [AW-1:0] a;
                    if ($urandom_range(0, 3) == 0) a = 13'($urandom);
                    else a = 13'($urandom_range(0, 7));
                    add_op(r, 1'($urandom_range(0, 1)), a, 8'($urandom));
                end
            end
            run_batch(2'($urandom_range(0, 3)));
        end

        check(exp_q.size() == 0, $sformatf("queue_drained got=%0d want=0", exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8 KB VRAM (sync write, async read) between three requesters: PPU tile/sprite fetch, OAM DMA engine and CPU.
- Sits between the gameboy core's VRAM-side buses and the VRAM async_mem instance, in the core `clock` domain.
- Fixed priority is PPU > DMA > CPU, with a starvation guard that promotes the CPU after repeated losses.
- Each requester sees a simple req/ack handshake with a held read-data register.

Parameters:
- AW, 13, VRAM address width (8192 bytes)
- DW, 8, data width
- MAX_WAIT, 4, number of lost arbitrations after which a pending CPU request is promoted to top priority (1..15)

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ppu_req, dma_req, cpu_req  in  1 each  access request; hold stable until ack
- ppu_we, dma_we, cpu_we  in  1 each  1 = write, 0 = read
- ppu_addr, dma_addr, cpu_addr  in  AW each  byte address
- ppu_wdata, dma_wdata, cpu_wdata  in  DW each  write data
- ppu_ack, dma_ack, cpu_ack  out  1 each  one-cycle completion pulse
- ppu_rdata, dma_rdata, cpu_rdata  out  DW each  read data; valid with ack, held until that requester's next read ack
- ppu_mode  in  2  current PPU mode; used only with VRAM_LOCKOUT_EN
- mem_addr  out  AW  to VRAM addr
- mem_wdata  out  DW  to VRAM wr_data
- mem_wr_cs  out  1  VRAM write strobe
- mem_rd_cs  out  1  VRAM read strobe
- mem_rdata  in  DW  VRAM combinational read data
- cpu_promoted  out  1  high while the starvation counter equals MAX_WAIT (debug)

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset state: FSM = IDLE; all acks 0; all rdata 8'h00; mem_addr 0; mem_wdata 0; mem_wr_cs/mem_rd_cs 0; starvation counter 0; cpu_promoted 0.
- Reset asserted mid-transaction aborts the access: no ack is issued and any write in flight is dropped. The strobe clears asynchronously.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req is high, pick a winner, register its id and latch its addr/we/wdata into the mem_* registers. Go to ACCESS. Otherwise stay in IDLE.
  - Priority: CPU first if the starvation counter == MAX_WAIT, otherwise PPU > DMA > CPU.
- ACCESS (exactly 1 cycle):
  - mem_wr_cs = we, mem_rd_cs = !we.
  - On a read, mem_rdata is captured at the closing edge into the winner's rdata register.
  - Go to ACK.
- ACK (1 cycle):
  - Winner's ack = 1; strobes deasserted.
  - No arbitration happens in this cycle. Requests are re-sampled in IDLE on the next cycle.
  - A requester must drop req in its ack cycle or the next IDLE sees a new request.
- Timing: req sampled in cycle N gives strobe in N+1 and ack in N+2. The minimum period between back-to-back accesses is 3 cycles.
- Starvation counter (4 bit):
  - +1 for each IDLE arbitration where cpu_req = 1 and CPU loses; saturates at MAX_WAIT.
  - Cleared when the CPU is granted.
  - Held when cpu_req = 0.
- Simultaneous requests resolve purely by priority in the same IDLE cycle. Losers keep req high and are re-arbitrated in the next IDLE.
- Write data for a non-winner is never sampled. A read leaves the other requesters' rdata registers unchanged.
- Address wrap: addresses are AW bits; no range checking.

Optional Feature:
- Macro: VRAM_LOCKOUT_EN.
- Defined:
  - When the CPU wins while ppu_mode == 2'b11, the arbiter still passes through ACCESS and ACK, but mem_wr_cs and mem_rd_cs stay 0.
  - For a locked-out read, cpu_rdata = 8'hFF. A locked-out write is discarded.
  - PPU and DMA are unaffected.
- Undefined: ppu_mode is ignored and the CPU always reaches memory.

Decomposition:
- Package vram_arb_pkg:
  - state enum {IDLE, ACCESS, ACK}
  - requester-id constants REQ_PPU=0, REQ_DMA=1, REQ_CPU=2
  - default widths
- Sub-module vram_arb_prio: combinational picker. Inputs are the three reqs plus the promote flag; outputs are a valid flag and a 2-bit winner id. Verified standalone.

Test Plan:
- Single CPU write addr 13'h0010 data 8'hA5, then CPU read of the same address: mem_wr_cs pulses in N+1, cpu_ack in N+2; the read returns cpu_rdata = 8'hA5 with cpu_ack 2 cycles after req.
- PPU, DMA and CPU all request in the same cycle: grants occur in the order PPU, DMA, CPU, with acks 3 cycles apart (cycles 2, 5, 8).
- PPU and DMA re-request continuously and CPU holds req, MAX_WAIT=4: CPU loses 4 times, cpu_promoted rises, CPU wins the 5th arbitration, and the counter returns to 0.
- Assert reset_n low during ACCESS of a DMA write to 13'h1FFF: no dma_ack; the prior memory contents at 13'h1FFF are unchanged on read-back; all outputs are 0 during reset.
- With VRAM_LOCKOUT_EN and ppu_mode=3, a CPU read of a location holding 8'h3C returns 8'hFF with no strobe. A CPU write of 8'h77 is dropped, and read-back with ppu_mode=0 gives 8'h3C.
- Addr 13'h1FFF then 13'h0000 back-to-back from DMA: correct data for both, and ppu_rdata/cpu_rdata are unchanged.
